// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter between the MEM/WB pipe and a long-latency result FIFO.
// Optional starvation guard enabled by defining WB_STARVE_GUARD_EN.
module wb_arbiter #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_we_i,
    input  logic [4:0]  pipe_waddr_i,
    input  logic [31:0] pipe_wdata_i,
    input  logic        lu_valid_i,
    input  logic [4:0]  lu_waddr_i,
    input  logic [31:0] lu_wdata_i,
    output logic        lu_ready_o,
    input  logic [4:0]  raddr1_i,
    input  logic [4:0]  raddr2_i,
    output logic        pend1_o,
    output logic        pend2_o,
    output logic        we_o,
    output logic [4:0]  waddr_o,
    output logic [31:0] wdata_o,
    output logic        stall_req_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] live_q, live_d;
    logic [4:0]       addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];

    logic empty, full;
    logic pipe_req, head_live;
    logic grant_pipe, grant_head;
    logic push, pop;
    logic stall_req;
    logic match1, match2;

    assign empty      = (count_q == '0);
    assign full       = (count_q == CW'(DEPTH));
    assign lu_ready_o = !full && !rst;

    // Writes to r0 are architecturally void, so they never request the port.
    assign pipe_req   = !rst && pipe_we_i && (pipe_waddr_i != 5'd0);
    assign head_live  = !empty && live_q[rd_ptr_q];
    assign grant_pipe = pipe_req && !stall_req;
    assign grant_head = head_live && !grant_pipe;

    // Results for r0 complete the handshake but are dropped on the floor.
    assign push = lu_valid_i && lu_ready_o && (lu_waddr_i != 5'd0);
    assign pop  = !empty && (!live_q[rd_ptr_q] || grant_head);

`ifdef WB_STARVE_GUARD_EN
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] starve_q, starve_d;

    always_comb begin
        starve_d = starve_q;
        if (pop || empty) begin
            starve_d = '0;
        end else if (head_live && grant_pipe) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    assign stall_req = !rst && (starve_q == SW'(STARVE_LIMIT));
`else
    logic unused_starve_limit;

    assign unused_starve_limit = ^STARVE_LIMIT;
    assign stall_req           = 1'b0;
`endif

    assign stall_req_o = stall_req;

    always_comb begin
        we_o    = 1'b0;
        waddr_o = 5'd0;
        wdata_o = 32'd0;
        if (grant_pipe) begin
            we_o    = 1'b1;
            waddr_o = pipe_waddr_i;
            wdata_o = pipe_wdata_i;
        end else if (grant_head) begin
            we_o    = 1'b1;
            waddr_o = addr_q[rd_ptr_q];
            wdata_o = data_q[rd_ptr_q];
        end
    end

    // Kill first, then pop, then push: a same-edge enqueue always survives the kill.
    always_comb begin
        live_d = live_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (grant_pipe && live_q[i] && (addr_q[i] == pipe_waddr_i) &&
                !(grant_head && (AW'(i) == rd_ptr_q))) begin
                live_d[i] = 1'b0;
            end
        end
        if (pop) begin
            live_d[rd_ptr_q] = 1'b0;
        end
        if (push) begin
            live_d[wr_ptr_q] = 1'b1;
        end
    end

    always_comb begin
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            live_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            live_q   <= live_d;
        end
    end

    // Payload storage needs no reset; validity lives entirely in live_q.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr_q] <= lu_waddr_i;
            data_q[wr_ptr_q] <= lu_wdata_i;
        end
    end

    always_comb begin
        match1 = 1'b0;
        match2 = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (live_q[i] && (addr_q[i] == raddr1_i)) begin
                match1 = 1'b1;
            end
            if (live_q[i] && (addr_q[i] == raddr2_i)) begin
                match2 = 1'b1;
            end
        end
        if (push && (lu_waddr_i == raddr1_i)) begin
            match1 = 1'b1;
        end
        if (push && (lu_waddr_i == raddr2_i)) begin
            match2 = 1'b1;
        end
    end

    assign pend1_o = !rst && match1 && (raddr1_i != 5'd0);
    assign pend2_o = !rst && match2 && (raddr2_i != 5'd0);

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter; covers the starvation guard when
// WB_STARVE_GUARD_EN is defined at compile time.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_waddr;
    logic [31:0] pipe_wdata;
    logic        lu_valid;
    logic [4:0]  lu_waddr;
    logic [31:0] lu_wdata;
    logic        lu_ready;
    logic [4:0]  raddr1, raddr2;
    logic        pend1, pend2;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        stall_req;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] rf [32];

    wb_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .pipe_we_i    (pipe_we),
        .pipe_waddr_i (pipe_waddr),
        .pipe_wdata_i (pipe_wdata),
        .lu_valid_i   (lu_valid),
        .lu_waddr_i   (lu_waddr),
        .lu_wdata_i   (lu_wdata),
        .lu_ready_o   (lu_ready),
        .raddr1_i     (raddr1),
        .raddr2_i     (raddr2),
        .pend1_o      (pend1),
        .pend2_o      (pend2),
        .we_o         (we),
        .waddr_o      (waddr),
        .wdata_o      (wdata),
        .stall_req_o  (stall_req)
    );

    always #5 clk = ~clk;

    // Shadow register file fed by the write port.
    always @(posedge clk) begin
        if (we) rf[waddr] <= wdata;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                         input logic lv, input logic [4:0] la, input logic [31:0] ld);
        pipe_we    = pwe;
        pipe_waddr = pa;
        pipe_wdata = pd;
        lu_valid   = lv;
        lu_waddr   = la;
        lu_wdata   = ld;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_wr(input string tag, input logic e_we, input logic [4:0] e_a,
                            input logic [31:0] e_d);
        check_eq({tag, ".we"}, we, e_we);
        check_eq({tag, ".waddr"}, waddr, e_a);
        check_eq({tag, ".wdata"}, wdata, e_d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with active inputs: everything must stay quiet.
        rst    = 1'b1;
        raddr1 = 5'd5;
        raddr2 = 5'd3;
        drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd5, 32'h9);
        check_wr("rst", 1'b0, 5'd0, 32'd0);
        check_eq("rst.lu_ready", lu_ready, 1'b0);
        check_eq("rst.pend1", pend1, 1'b0);
        check_eq("rst.pend2", pend2, 1'b0);
        check_eq("rst.stall", stall_req, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        check_wr("idle", 1'b0, 5'd0, 32'd0);
        check_eq("idle.lu_ready", lu_ready, 1'b1);

        // Pipe write on idle FIFO goes straight through.
        next_cycle();
        drive(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'd0);
        check_wr("pipe3", 1'b1, 5'd3, 32'h11);
        check_eq("pipe3.lu_ready", lu_ready, 1'b1);

        // Pipe write to r0 is no write.
        next_cycle();
        drive(1'b1, 5'd0, 32'h99, 1'b0, 5'd0, 32'd0);
        check_wr("pipe0", 1'b0, 5'd0, 32'd0);

        // Single push, written when the pipe goes idle.
        raddr1 = 5'd5;
        next_cycle();
        drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd5, 32'hAB);
        check_wr("push5", 1'b1, 5'd2, 32'h22);
        check_eq("push5.pend1", pend1, 1'b1);
        next_cycle();
        idle();
        check_wr("pop5", 1'b1, 5'd5, 32'hAB);
        check_eq("pop5.pend1", pend1, 1'b1);
        next_cycle();
        idle();
        check_wr("after5", 1'b0, 5'd0, 32'd0);
        check_eq("after5.pend1", pend1, 1'b0);

        // Fill the FIFO while the pipe owns the port.
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            drive(1'b1, 5'd1, 32'h100 + k, 1'b1, 5'(8 + k), 32'h80 + k);
            check_wr("fill", 1'b1, 5'd1, 32'h100 + k);
            check_eq("fill.lu_ready", lu_ready, 1'b1);
        end
        raddr1 = 5'd10;
        raddr2 = 5'd12;
        next_cycle();
        drive(1'b1, 5'd1, 32'h1FF, 1'b1, 5'd12, 32'h8C);
        check_eq("full.lu_ready", lu_ready, 1'b0);
        check_wr("full", 1'b1, 5'd1, 32'h1FF);
        check_eq("full.pend1", pend1, 1'b1);
        check_eq("full.pend2", pend2, 1'b0);
        next_cycle();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'h8C);
        check_wr("drain8", 1'b1, 5'd8, 32'h80);
        check_eq("drain8.lu_ready", lu_ready, 1'b0);
        next_cycle();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'h8C);
        check_eq("drain9.lu_ready", lu_ready, 1'b1);
        check_wr("drain9", 1'b1, 5'd9, 32'h81);
        check_eq("drain9.pend2", pend2, 1'b1);
        next_cycle();
        idle();
        check_wr("drain10", 1'b1, 5'd10, 32'h82);
        next_cycle();
        idle();
        check_wr("drain11", 1'b1, 5'd11, 32'h83);
        next_cycle();
        idle();
        check_wr("drain12", 1'b1, 5'd12, 32'h8C);
        next_cycle();
        idle();
        check_wr("drained", 1'b0, 5'd0, 32'd0);

        // WAW kill: pipe overwrites r7 while its FIFO result is pending.
        raddr1 = 5'd7;
        raddr2 = 5'd0;
        next_cycle();
        drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd7, 32'h77);
        check_wr("kpush", 1'b1, 5'd4, 32'h44);
        next_cycle();
        drive(1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 32'd0);
        check_wr("kill7", 1'b1, 5'd7, 32'h22);
        check_eq("kill7.pend1", pend1, 1'b1);
        next_cycle();
        idle();
        check_wr("dead7", 1'b0, 5'd0, 32'd0);
        check_eq("dead7.pend1", pend1, 1'b0);
        next_cycle();
        idle();
        check_wr("empty7", 1'b0, 5'd0, 32'd0);
        check_eq("rf7", rf[7], 32'h22);

        // Entry pushed on the kill edge survives.
        raddr1 = 5'd6;
        next_cycle();
        drive(1'b1, 5'd4, 32'h45, 1'b1, 5'd6, 32'h66);
        check_wr("spush", 1'b1, 5'd4, 32'h45);
        next_cycle();
        drive(1'b1, 5'd6, 32'h44, 1'b1, 5'd6, 32'h67);
        check_wr("skill", 1'b1, 5'd6, 32'h44);
        next_cycle();
        idle();
        check_wr("sdead", 1'b0, 5'd0, 32'd0);
        check_eq("sdead.pend1", pend1, 1'b1);
        next_cycle();
        idle();
        check_wr("slive", 1'b1, 5'd6, 32'h67);
        next_cycle();
        idle();
        check_eq("sdone.pend1", pend1, 1'b0);

        // Results for r0 are accepted but never stored.
        raddr1 = 5'd0;
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55);
            check_eq("r0push.lu_ready", lu_ready, 1'b1);
            check_eq("r0push.we", we, 1'b0);
        end
        next_cycle();
        idle();
        check_wr("r0done", 1'b0, 5'd0, 32'd0);

        // Continuous pipe writes against one live head.
        raddr1 = 5'd13;
        next_cycle();
        drive(1'b1, 5'd2, 32'h200, 1'b1, 5'd13, 32'hD0);
        check_wr("starve0", 1'b1, 5'd2, 32'h200);
        check_eq("starve0.stall", stall_req, 1'b0);
        for (int c = 1; c <= 8; c++) begin
            next_cycle();
            drive(1'b1, 5'd2, 32'h200 + c, 1'b0, 5'd0, 32'd0);
            check_eq("starve.stall", stall_req, 1'b0);
            check_wr("starve", 1'b1, 5'd2, 32'h200 + c);
            check_eq("starve.pend1", pend1, 1'b1);
        end
`ifdef WB_STARVE_GUARD_EN
        next_cycle();
        drive(1'b1, 5'd2, 32'h209, 1'b0, 5'd0, 32'd0);
        check_eq("stall9", stall_req, 1'b1);
        check_wr("stall9", 1'b1, 5'd13, 32'hD0);
        next_cycle();
        drive(1'b1, 5'd2, 32'h209, 1'b0, 5'd0, 32'd0);
        check_eq("stall10", stall_req, 1'b0);
        check_wr("stall10", 1'b1, 5'd2, 32'h209);
        check_eq("stall10.pend1", pend1, 1'b0);
`else
        next_cycle();
        drive(1'b1, 5'd2, 32'h209, 1'b0, 5'd0, 32'd0);
        check_eq("nostall9", stall_req, 1'b0);
        check_wr("nostall9", 1'b1, 5'd2, 32'h209);
        next_cycle();
        idle();
        check_wr("nostall.pop", 1'b1, 5'd13, 32'hD0);
`endif
        next_cycle();
        idle();
        check_wr("starve.done", 1'b0, 5'd0, 32'd0);
        check_eq("starve.done.pend1", pend1, 1'b0);

        // Reset in the middle of a handshake.
        raddr1 = 5'd9;
        raddr2 = 5'd10;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            drive(1'b1, 5'd1, 32'h300 + k, 1'b1, 5'(9 + k), 32'h90 + k);
        end
        next_cycle();
        drive(1'b1, 5'd1, 32'h303, 1'b1, 5'd12, 32'h93);
        check_eq("prerst.pend1", pend1, 1'b1);
        check_eq("prerst.lu_ready", lu_ready, 1'b1);
        rst = 1'b1;
        #1;
        check_eq("midrst.we", we, 1'b0);
        check_eq("midrst.lu_ready", lu_ready, 1'b0);
        check_eq("midrst.pend1", pend1, 1'b0);
        check_eq("midrst.pend2", pend2, 1'b0);
        check_eq("midrst.stall", stall_req, 1'b0);
        next_cycle();
        rst = 1'b0;
        idle();
        check_wr("postrst", 1'b0, 5'd0, 32'd0);
        check_eq("postrst.lu_ready", lu_ready, 1'b1);
        check_eq("postrst.pend1", pend1, 1'b0);
        check_eq("postrst.pend2", pend2, 1'b0);
        next_cycle();
        idle();
        check_wr("postrst2", 1'b0, 5'd0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter DEPTH, 4, long-latency result FIFO entries; power of two, >=2.
REQ-002 Parameter STARVE_LIMIT, 8, consecutive blocked cycles before the pipeline is stalled (used only under WB_STARVE_GUARD_EN).
REQ-003 clk  in  1  single clock; all state changes on posedge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 pipe_we / pipe_waddr / pipe_wdata  in  1/5/32  writeback from the MEM/WB stage.
REQ-006 lu_valid / lu_waddr / lu_wdata  in  1/5/32  long-latency unit (mul/div) result offer.
REQ-007 lu_ready  out  1  FIFO can accept a result this cycle.
REQ-008 raddr1, raddr2  in  5  decode-stage read addresses for pending checks.
REQ-009 pend1, pend2  out  1  a live FIFO entry targets raddr1 / raddr2.
REQ-010 we / waddr / wdata  out  1/5/32  register file write port.
REQ-011 stall_req  out  1  request to freeze the pipeline.

Function
REQ-012 Port grant SHALL be combinational: pipe_we=1 with pipe_waddr!=0 wins the write port unless stall_req=1; otherwise a live FIFO head wins.
REQ-013 A pipe write to address 0 SHALL NOT drive we; it counts as no pipeline request.
REQ-014 we=0 with waddr=0 and wdata=0 SHALL be driven when nothing is granted.
REQ-015 lu_ready SHALL equal NOT full, independent of a same-cycle pop.
REQ-016 lu_valid AND lu_ready SHALL enqueue {live=1, lu_waddr, lu_wdata} at the tail on the clock edge.
REQ-017 An accepted result with lu_waddr=0 SHALL complete the handshake and be discarded without occupying a slot.
REQ-018 A granted live head SHALL be written and popped on the same edge, giving zero-cycle latency from head to port.
REQ-019 A dead head (live=0) SHALL be popped in any cycle without driving we, independent of the pipeline grant.
REQ-020 A granted pipe write SHALL clear live on every FIFO entry with a matching address (WAW kill), except a head entry being written in the same cycle.
REQ-021 An entry enqueued on the same edge as a kill SHALL NOT be killed.
REQ-022 Simultaneous push and pop SHALL both occur; occupancy stays unchanged; pointers wrap modulo DEPTH.
REQ-023 pendN SHALL be 1 iff raddrN!=0 and any live entry, or the incoming lu_valid&&lu_ready entry, matches raddrN.

Reset
REQ-024 rst SHALL asynchronously clear pointers, occupancy, all live bits and the starve counter.
REQ-025 During rst: we=0, lu_ready=0, pend1=pend2=0, stall_req=0; FIFO contents after reset SHALL be lost, including any mid-handshake entry.

Configuration
REQ-026 With WB_STARVE_GUARD_EN defined, a counter SHALL increment each cycle a live head is blocked by a pipe grant, and clear on pop or when the FIFO is empty.
REQ-027 With WB_STARVE_GUARD_EN defined, stall_req SHALL be 1 while counter==STARVE_LIMIT, granting the head (REQ-012); the pipeline holds its write and is granted after the pop.
REQ-028 Without WB_STARVE_GUARD_EN, no counter SHALL exist, stall_req SHALL be constant 0, and the pipeline always wins.

Verification
REQ-029 Idle FIFO; pipe_we=1, pipe_waddr=3, pipe_wdata=0x11 -> same cycle we=1, waddr=3, wdata=0x11; lu_ready=1.
REQ-030 lu push addr 5, data 0xAB; pipe idle next cycle -> we=1, waddr=5, wdata=0xAB on that cycle; FIFO empty after; pend(raddr1=5) is 1 until the pop edge.
REQ-031 Four pushes with the pipe writing every cycle -> lu_ready=0 after the fourth; fifth offer held; with the guard off, no FIFO write occurs while pipe_we=1.
REQ-032 FIFO entry addr 7; pipe writes addr 7 data 0x22 -> entry killed, pend(7)=0, later head pop drives no write; regfile r7=0x22.
REQ-033 WB_STARVE_GUARD_EN defined, STARVE_LIMIT=8, pipe writing continuously, one live head -> stall_req=1 on the 9th cycle, head written, stall_req=0 next cycle, then the pipe write is granted.
REQ-034 Assert rst with 3 entries mid-handshake -> we=0, lu_ready=0 immediately; after release, FIFO empty and pend1=pend2=0.
